// File: rtl/pong_paddle_poller_if.sv
// Command/response bus between the paddle poller and the byte-level I2C
// master engine. The engine owns the scl/sda pins; this bus only carries
// byte-level commands and their completions.
//
//   cmd_valid  poller -> engine  command valid, held with stable op/data until cmd_ready
//   cmd_ready  engine -> poller  command accepted on cmd_valid & cmd_ready
//   cmd_op     poller -> engine  0=START 1=WRITE 2=READ_NACK 3=STOP
//   cmd_data   poller -> engine  address byte for WRITE, 0 otherwise
//   cmd_done   engine -> poller  1-cycle pulse: accepted command finished
//   rsp_ack    engine -> poller  slave ACK, valid with cmd_done of a WRITE
//   rsp_data   engine -> poller  read byte, valid with cmd_done of a READ_NACK
//   eng_abort  poller -> engine  1-cycle pulse: drop current op, release the bus
interface pong_paddle_poller_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_done;
    logic       rsp_ack;
    logic [7:0] rsp_data;
    logic       eng_abort;

    modport master (
        output cmd_valid, cmd_op, cmd_data, eng_abort,
        input  cmd_ready, cmd_done, rsp_ack, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, eng_abort,
        output cmd_ready, cmd_done, rsp_ack, rsp_data
    );
endinterface

// File: rtl/pong_paddle_poller.sv
// Per-frame paddle poller. On each accepted frame-start pulse it walks the
// I2C engine through START, WRITE(addr|R), READ_NACK, STOP for player 0 and
// then for player 1, and latches each paddle value once its STOP completes.
// NACKed or timed-out devices keep their old value and flag dev_err.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_enable         polling enable (frame_start ignored when low)
//   i_frame_start    1-cycle frame pulse
//   bus              command/response bus to the I2C engine (master side)
//   o_paddle0/1      latest good paddle values
//   o_update         1-cycle pulse when a poll round finishes
//   o_dev_err        per-device error flags of the last poll
//   o_busy           poll round in progress
//   o_overrun_cnt    saturating count of frame pulses dropped while busy
module pong_paddle_poller #(
    parameter logic [6:0]  DEV0_ADDR   = 7'h52,
    parameter logic [6:0]  DEV1_ADDR   = 7'h53,
    parameter int unsigned TIMEOUT     = 4096,
    parameter logic [7:0]  PADDLE_INIT = 8'd128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_enable,
    input  logic                    i_frame_start,
    pong_paddle_poller_if.master    bus,
    output logic [7:0]              o_paddle0,
    output logic [7:0]              o_paddle1,
    output logic                    o_update,
    output logic [1:0]              o_dev_err,
    output logic                    o_busy,
    output logic [7:0]              o_overrun_cnt
);
    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_READ, S_STOP, S_DONE
    } state_t;

    state_t        r_state;
    logic          r_wait;       // 0 = ISSUE phase, 1 = WAIT phase
    logic [CW-1:0] r_cnt;
    logic          r_dev;
    logic          r_got;        // READ completed for the current device
    logic [7:0]    r_rdata;
    logic          r_cmd_valid;
    logic [1:0]    r_cmd_op;
    logic [7:0]    r_cmd_data;
    logic          r_eng_abort;
    logic [7:0]    r_paddle0;
    logic [7:0]    r_paddle1;
    logic          r_update;
    logic [1:0]    r_dev_err;
    logic          r_busy;
    logic [7:0]    r_overrun;

    logic          w_cmd_state;
    logic          w_hs;
    logic          w_timeout;
    logic          w_done_evt;
    logic          w_abort_evt;
    logic          w_start;
    logic [6:0]    w_dev_addr;
    state_t        w_go_state;
    logic [1:0]    w_go_op;

    assign w_cmd_state = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_hs        = r_cmd_valid & bus.cmd_ready;
    assign w_timeout   = (r_cnt == TMAX);
    assign w_done_evt  = w_cmd_state & r_wait & bus.cmd_done;
    // Completion or acceptance in the deadline cycle still wins over the abort.
    assign w_abort_evt = w_cmd_state & w_timeout & ~w_done_evt & (r_wait | ~w_hs);
    assign w_start     = i_frame_start & i_enable;
    assign w_dev_addr  = r_dev ? DEV1_ADDR : DEV0_ADDR;

    // Successor state when the current command ends (completed or aborted).
    // An abort skips the rest of this device, STOP included.
    always_comb begin
        w_go_state = r_state;
        if (w_abort_evt) begin
            w_go_state = r_dev ? S_DONE : S_START;
        end else begin
            case (r_state)
                S_START: w_go_state = S_ADDR;
                S_ADDR:  w_go_state = bus.rsp_ack ? S_READ : S_STOP;
                S_READ:  w_go_state = S_STOP;
                S_STOP:  w_go_state = r_dev ? S_DONE : S_START;
                default: w_go_state = r_state;
            endcase
        end
        case (w_go_state)
            S_START: w_go_op = OP_START;
            S_ADDR:  w_go_op = OP_WRITE;
            S_READ:  w_go_op = OP_READ;
            default: w_go_op = OP_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait      <= 1'b0;
            r_cnt       <= '0;
            r_dev       <= 1'b0;
            r_got       <= 1'b0;
            r_rdata     <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_START;
            r_cmd_data  <= 8'h00;
            r_eng_abort <= 1'b0;
            r_paddle0   <= PADDLE_INIT;
            r_paddle1   <= PADDLE_INIT;
            r_update    <= 1'b0;
            r_dev_err   <= 2'b00;
            r_busy      <= 1'b0;
            r_overrun   <= 8'h00;
        end else begin
            r_eng_abort <= 1'b0;
            r_update    <= 1'b0;

            // The DONE cycle already shows busy=0 but still drops the request.
            if (w_start && (r_state != S_IDLE) && (r_overrun != 8'hFF))
                r_overrun <= r_overrun + 8'd1;

            if (r_state == S_IDLE) begin
                if (w_start) begin
                    r_state     <= S_START;
                    r_dev       <= 1'b0;
                    r_got       <= 1'b0;
                    r_busy      <= 1'b1;
                    r_cmd_valid <= 1'b1;
                    r_cmd_op    <= OP_START;
                    r_cmd_data  <= 8'h00;
                    r_wait      <= 1'b0;
                    r_cnt       <= '0;
                end
            end else if (r_state == S_DONE) begin
                r_state <= S_IDLE;
            end else if (w_done_evt || w_abort_evt) begin
                if (w_abort_evt) begin
                    r_eng_abort      <= 1'b1;
                    r_dev_err[r_dev] <= 1'b1;
                end else begin
                    case (r_state)
                        S_ADDR: if (!bus.rsp_ack) r_dev_err[r_dev] <= 1'b1;
                        S_READ: begin
                            r_rdata <= bus.rsp_data;
                            r_got   <= 1'b1;
                        end
                        S_STOP: if (r_got) begin
                            // Paddle only changes once the bus is released.
                            if (r_dev) r_paddle1 <= r_rdata;
                            else       r_paddle0 <= r_rdata;
                            r_dev_err[r_dev] <= 1'b0;
                        end
                        default: ;
                    endcase
                end

                r_state <= w_go_state;
                if (w_go_state == S_DONE) begin
                    r_cmd_valid <= 1'b0;
                    r_cmd_op    <= OP_START;
                    r_cmd_data  <= 8'h00;
                    r_busy      <= 1'b0;
                    r_update    <= 1'b1;
                end else begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_op    <= w_go_op;
                    r_cmd_data  <= (w_go_state == S_ADDR) ? {w_dev_addr, 1'b1} : 8'h00;
                    r_wait      <= 1'b0;
                    r_cnt       <= '0;
                end
                // START is only re-entered when moving from player 0 to player 1.
                if (w_go_state == S_START) begin
                    r_dev <= 1'b1;
                    r_got <= 1'b0;
                end
            end else if (!r_wait && w_hs) begin
                r_cmd_valid <= 1'b0;
                r_wait      <= 1'b1;
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_op    = r_cmd_op;
    assign bus.cmd_data  = r_cmd_data;
    assign bus.eng_abort = r_eng_abort;
    assign o_paddle0     = r_paddle0;
    assign o_paddle1     = r_paddle1;
    assign o_update      = r_update;
    assign o_dev_err     = r_dev_err;
    assign o_busy        = r_busy;
    assign o_overrun_cnt = r_overrun;
endmodule
